// File: rtl/vga_pmod_tx.sv
// ============================================================================
// vga_pmod_tx : 640x480 VGA timing plus test-pattern source for a TinyVGA PMOD
// Rev 1.0     : initial release
// ============================================================================
`default_nettype none

module vga_pmod_tx #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [1:0] pattern_sel,
  output logic [7:0] pmod_out,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       video_active,
  output logic       frame_start
);

  localparam logic [9:0] c_h_active   = 10'(H_ACTIVE);
  localparam logic [9:0] c_h_max      = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] c_hs_first   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] c_hs_last    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] c_v_active   = 10'(V_ACTIVE);
  localparam logic [9:0] c_v_max      = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] c_vs_first   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] c_vs_last    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam int         c_bar_w      = H_ACTIVE / 8;
  localparam logic [7:0] c_pmod_blank = 8'h88;

  logic [9:0] x_q, y_q;
  logic [7:0] fcnt_q;
  logic [1:0] pat_q;
  logic [7:0] pmod_q;
  logic       fs_q;

  logic       w_x_last, w_y_last, w_frame_wrap, w_origin, w_active;
  logic       w_hsync, w_vsync, w_chk;
  logic [9:0] w_x_d, w_y_d;
  logic [1:0] w_pat;
  logic [2:0] w_bar;
  logic [5:0] w_grad;
  logic [1:0] w_r, w_g, w_b;
  logic [7:0] w_pmod_d;

  always_comb begin
    w_x_last     = (x_q == c_h_max);
    w_y_last     = (y_q == c_v_max);
    w_frame_wrap = w_x_last && w_y_last;
    w_origin     = (x_q == 10'd0) && (y_q == 10'd0);
    w_x_d        = w_x_last ? 10'd0 : x_q + 10'd1;
    if (w_x_last) begin
      w_y_d = w_y_last ? 10'd0 : y_q + 10'd1;
    end else begin
      w_y_d = y_q;
    end
    w_active = (x_q < c_h_active) && (y_q < c_v_active);
    w_hsync  = !((x_q >= c_hs_first) && (x_q <= c_hs_last));
    w_vsync  = !((y_q >= c_vs_first) && (y_q <= c_vs_last));
  end

  // The origin pixel must already use the pattern being latched on this edge.
  assign w_pat = w_origin ? pattern_sel : pat_q;

  always_comb begin
    w_bar = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (x_q >= 10'(k * c_bar_w)) begin
        w_bar = 3'(k);
      end
    end
  end

  assign w_chk  = x_q[5] ^ y_q[5] ^ fcnt_q[5];
  assign w_grad = x_q[7:2] + fcnt_q[5:0];

  always_comb begin
    w_r = 2'b00;
    w_g = 2'b00;
    w_b = 2'b00;
    case (w_pat)
      2'd1: begin
        w_r = {2{w_bar[0]}};
        w_g = {2{w_bar[1]}};
        w_b = {2{w_bar[2]}};
      end
      2'd2: begin
        w_r = {2{w_chk}};
        w_g = {2{w_chk}};
        w_b = {2{w_chk}};
      end
      2'd3: begin
        w_r = w_grad[5:4];
        w_g = w_grad[3:2];
        w_b = w_grad[1:0];
      end
      default: ;
    endcase
    if (!w_active) begin
      w_r = 2'b00;
      w_g = 2'b00;
      w_b = 2'b00;
    end
    w_pmod_d = {w_hsync, w_b[0], w_g[0], w_r[0], w_vsync, w_b[1], w_g[1], w_r[1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q    <= 10'd0;
      y_q    <= 10'd0;
      fcnt_q <= 8'd0;
      pat_q  <= 2'd0;
      pmod_q <= c_pmod_blank;
      fs_q   <= 1'b0;
    end else if (ena) begin
      x_q    <= w_x_d;
      y_q    <= w_y_d;
      if (w_frame_wrap) begin
        fcnt_q <= fcnt_q + 8'd1;
      end
      if (w_origin) begin
        pat_q <= pattern_sel;
      end
      pmod_q <= w_pmod_d;
      fs_q   <= w_origin;
    end
  end

  assign pmod_out     = pmod_q;
  assign frame_start  = fs_q;
  assign pix_x        = x_q;
  assign pix_y        = y_q;
  assign video_active = w_active;

endmodule

`default_nettype wire

// File: tb/tb_vga_pmod_tx.sv
// Directed bench for vga_pmod_tx; vertical timing shortened to 15 lines (8 active,
// sync on lines 10..11) so several frames fit in a short run.
`default_nettype none

module tb_vga_pmod_tx;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [1:0] pattern_sel;
  logic [7:0] pmod_out;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       video_active;
  logic       frame_start;

  int n_cmp = 0;
  int n_err = 0;

  vga_pmod_tx #(
    .V_ACTIVE(8),
    .V_FP    (2),
    .V_SYNC  (2),
    .V_BP    (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .pattern_sel (pattern_sel),
    .pmod_out    (pmod_out),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .video_active(video_active),
    .frame_start (frame_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_xy(input string tag, input int x, input int y, input int max_ticks);
    int n;
    n = 0;
    while (!(int'(pix_x) == x && int'(pix_y) == y) && n < max_ticks) begin
      tick();
      n++;
    end
    check(tag, {31'd0, (int'(pix_x) == x && int'(pix_y) == y)}, 32'd1);
  endtask

  initial begin
    int  hs_low, hs_first_x, hs_falls, col_bad, va_bad, vs_low, fs_cnt, n, x;
    logic prev_hs;
    logic [7:0] exp8, hold;

    rst_n       = 1'b0;
    ena         = 1'b1;
    pattern_sel = 2'd0;
    tick();
    tick();
    check("rst_pmod", pmod_out, 32'h88);
    check("rst_x", pix_x, 0);
    check("rst_y", pix_y, 0);
    check("rst_fs", frame_start, 0);
    check("rst_va", video_active, 1);

    // Line 0, black pattern: hsync window, blank colours, active flag.
    rst_n = 1'b1;
    hs_low = 0; hs_first_x = -1; hs_falls = 0; col_bad = 0; va_bad = 0;
    prev_hs = 1'b1;
    for (int i = 1; i <= 800; i++) begin
      tick();
      if (i == 1) check("fs_first", frame_start, 1);
      if (pmod_out[7] == 1'b0) begin
        hs_low++;
        if (hs_first_x < 0) hs_first_x = int'(pix_x);
      end
      if (prev_hs && !pmod_out[7]) hs_falls++;
      prev_hs = pmod_out[7];
      if ((pmod_out & 8'h77) != 8'h00) col_bad++;
      if (video_active !== (pix_x < 10'd640 && pix_y < 10'd8)) va_bad++;
    end
    check("hs_low_len", hs_low, 96);
    check("hs_first_x", hs_first_x, 657);
    check("hs_falls", hs_falls, 1);
    check("black_cols", col_bad, 0);
    check("va_view", va_bad, 0);
    check("line1_x", pix_x, 0);
    check("line1_y", pix_y, 1);

    // Rest of the frame plus the first edge of the next one.
    vs_low = 0; fs_cnt = 0;
    for (int i = 0; i < 11201; i++) begin
      tick();
      if (!pmod_out[3]) vs_low++;
      if (frame_start) fs_cnt++;
    end
    check("vs_low_len", vs_low, 1600);
    check("fs_per_frame", fs_cnt, 1);
    check("frame2_x", pix_x, 1);
    check("frame2_y", pix_y, 0);

    // Colour bars on line 0 after reset.
    rst_n = 1'b0;
    pattern_sel = 2'd1;
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 656; k++) begin
      tick();
      x = k - 1;
      exp8 = (x < 640) ? 8'(8'h88 + 8'h11 * (x / 80)) : 8'h88;
      check($sformatf("bars_x%0d", x), pmod_out, {24'd0, exp8});
    end

    // Mid-frame switch to checker must not take effect until the next frame.
    wait_xy("reach_y4", 0, 4, 4000);
    pattern_sel = 2'd2;
    wait_xy("reach_201_4", 201, 4, 1000);
    check("bars_hold", pmod_out, 32'hAA);
    wait_xy("reach_f1", 0, 0, 13000);
    tick();
    check("chk_0_0", pmod_out, 32'h88);
    check("chk_fs", frame_start, 1);
    wait_xy("reach_33", 33, 0, 100);
    check("chk_32_0", pmod_out, 32'hFF);
    wait_xy("reach_65", 65, 0, 100);
    check("chk_64_0", pmod_out, 32'h88);

    // Gradient in frame_cnt=2: v = x[7:2] + 2.
    pattern_sel = 2'd3;
    wait_xy("reach_f2", 0, 0, 13000);
    tick();
    check("grad_x0", pmod_out, 32'h8C);
    wait_xy("reach_21", 21, 0, 100);
    check("grad_x20", pmod_out, 32'hEC);
    wait_xy("reach_253", 253, 0, 300);
    check("grad_x252", pmod_out, 32'hC8);

    // Enable low freezes everything.
    wait_xy("reach_300", 300, 0, 100);
    check("grad_x299", pmod_out, 32'hAA);
    hold = pmod_out;
    ena = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      check("hold_x", pix_x, 300);
      check("hold_pmod", pmod_out, {24'd0, hold});
    end
    ena = 1'b1;
    wait_xy("reach_656", 656, 0, 400);
    check("hs_before", pmod_out[7], 1);
    tick();
    check("hs_resume_x", pix_x, 657);
    check("hs_resume_low", pmod_out[7], 0);

    // Reset during the vsync pulse.
    wait_xy("reach_vs", 5, 11, 13000);
    check("vs_in_pulse", pmod_out[3], 0);
    rst_n = 1'b0;
    tick();
    check("mrst_pmod", pmod_out, 32'h88);
    check("mrst_x", pix_x, 0);
    check("mrst_y", pix_y, 0);
    check("mrst_fs", frame_start, 0);
    rst_n = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (pmod_out[3] && n < 20000);
    check("vs_after_rst", n, 8001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
